// File: rtl/cr_mem_rd_streamer_if.sv
// cr_mem_rd_streamer_if: command, RAM read port and output stream bundle for the burst read streamer
interface cr_mem_rd_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              mem_rd_read;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rd_data, mem_rd_valid, out_ready,
    output cmd_ready, mem_rd_read, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rd_data, mem_rd_valid, out_ready,
    input  cmd_ready, mem_rd_read, mem_rd_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/cr_mem_rd_streamer.sv
// cr_mem_rd_streamer: burst RAM reader with credit-controlled FWFT return FIFO feeding a valid/ready stream
module cr_mem_rd_streamer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 9
) (
  input logic                   clk,
  input logic                   reset_n,
  cr_mem_rd_streamer_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d, ret_q, ret_d;
  logic [CW-1:0]     infl_q, infl_d, occ_q, occ_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic              cmd_fire, issue, wr, pop, head_last;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    head_last = mem_q[rd_ptr_q][DATA_W];
    cmd_fire  = state_q == IDLE && bus.cmd_valid;
    // credit: words already buffered plus reads still in the RAM pipeline must fit in the FIFO
    issue     = state_q == RUN && rem_q != '0 && ({1'b0, occ_q} + {1'b0, infl_q} < (CW+1)'(FIFO_DEPTH));
    wr        = bus.mem_rd_valid && infl_q != '0;
    pop       = occ_q != '0 && bus.out_ready;
    state_d   = state_q;
    addr_d    = issue ? addr_q + ADDR_W'(1) : addr_q;
    rem_d     = issue ? rem_q - LEN_W'(1) : rem_q;
    ret_d     = wr ? ret_q - LEN_W'(1) : ret_q;
    infl_d    = infl_q + CW'(issue) - CW'(wr);
    occ_d     = occ_q + CW'(wr) - CW'(pop);
    wr_ptr_d  = wr ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    done_d    = cmd_fire && bus.cmd_len == '0;
    if (cmd_fire && bus.cmd_len != '0) begin
      addr_d  = bus.cmd_addr;
      rem_d   = bus.cmd_len;
      ret_d   = bus.cmd_len;
      state_d = RUN;
    end
    if (issue && rem_q == LEN_W'(1)) state_d = DRAIN;
    if (state_q == DRAIN && pop && head_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      ret_q    <= '0;
      infl_q   <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      ret_q    <= ret_d;
      infl_q   <= infl_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end
  // the final return of the burst is tagged as last when it enters the FIFO
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {ret_q == LEN_W'(1), bus.mem_rd_data};
  end
  assign bus.cmd_ready   = state_q == IDLE;
  assign bus.mem_rd_read = issue;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_valid   = occ_q != '0;
  assign bus.out_data    = mem_q[rd_ptr_q][DATA_W-1:0];
  assign bus.out_last    = occ_q != '0 && head_last;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(wr && !pop && occ_q == CW'(FIFO_DEPTH))) else $error("return FIFO overflow");
  a_len_legal: assert property (@(posedge clk) disable iff (!reset_n)
    cmd_fire |-> bus.cmd_len <= LEN_W'(2 ** ADDR_W)) else $error("burst length too large");
  a_infl_bound: assert property (@(posedge clk) disable iff (!reset_n)
    infl_q <= CW'(RD_LATENCY)) else $error("more reads outstanding than RAM latency");
endmodule

// File: doc/cr_mem_rd_streamer.md
Name: cr_mem_rd_streamer

Overview:
Read-side master for the 256x16 RAM block. It accepts a burst command (start address, length) and issues one-word reads on the RAM read port. It absorbs the RAM's fixed read latency in a credit-controlled FWFT FIFO and presents the words as a valid/ready stream with a last flag. It sits between the RAM read port and a downstream stream consumer.

Parameters:
ADDR_W, 8, RAM address width; addresses wrap modulo 2**ADDR_W
DATA_W, 16, RAM data width
RD_LATENCY, 4, cycles from mem_rd_read asserted to mem_rd_valid asserted (fixed by the RAM)
FIFO_DEPTH, 8, return FIFO depth; must be >= RD_LATENCY+2 for full throughput
LEN_W, 9, burst length width; allows lengths 0..256

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_addr  input  ADDR_W  burst start address
cmd_len  input  LEN_W  number of words to read
mem_rd_read  output  1  read strobe to RAM, one word per asserted cycle
mem_rd_addr  output  ADDR_W  read address to RAM
mem_rd_data  input  DATA_W  read data from RAM
mem_rd_valid  input  1  read data valid from RAM
out_valid  output  1  stream word valid
out_ready  input  1  downstream accepts word
out_data  output  DATA_W  stream word
out_last  output  1  final word of burst, qualified by out_valid
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (reset_n=0 at an edge) has priority over every other event. It forces: state=IDLE; cmd_ready=1 from the next cycle; mem_rd_read=0; mem_rd_addr=0; out_valid=0; out_last=0; busy=0; done=0. It also clears the FIFO occupancy, the inflight counter and the remaining-word counter.
- FSM has three states: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - Handshake with cmd_len!=0: latch the address, set remaining=cmd_len, go to RUN.
  - Handshake with cmd_len==0: stay in IDLE; done pulses in the next cycle. No reads are issued.
- RUN:
  - cmd_ready=0.
  - mem_rd_read is asserted in a cycle only when occupancy+inflight < FIFO_DEPTH (credit check).
  - Each issued read: addr+1 (FF wraps to 00), remaining-1, inflight+1.
  - When the last read is issued, go to DRAIN.
- DRAIN:
  - No reads are issued.
  - Leave when the word flagged last is accepted (out_valid & out_ready & out_last): done=1 next cycle, go to IDLE.
  - The next command can be accepted in the cycle done is high.
- Inflight counter:
  - Increments on each issue, decrements on mem_rd_valid.
  - If issue and return happen in the same cycle, the counter is unchanged.
  - mem_rd_valid while inflight==0 is dropped and not written to the FIFO. This covers stale returns after a reset in the middle of a burst.
- FIFO:
  - A return word is written on mem_rd_valid (when inflight>0).
  - First-word-fall-through: a word written at edge E is visible on out_data/out_valid in the cycle after E.
  - Simultaneous write and pop leaves occupancy unchanged.
  - The credit check guarantees the FIFO never overflows. An overflow is an assertion failure.
  - Each entry carries a last bit, set on the return of the final read of the burst; it is tracked by a returned-word counter.
- Stream output:
  - out_data, out_last and out_valid hold stable while out_valid & ~out_ready.
- Latency: command handshake in cycle T, first mem_rd_read in T+1, mem_rd_valid in T+1+RD_LATENCY, first out_valid in T+2+RD_LATENCY (T+6 at default).
- Throughput: one word per cycle sustained with out_ready=1 and FIFO_DEPTH>=RD_LATENCY+2.
- Backpressure: with out_ready=0, reads stop once occupancy+inflight reaches FIFO_DEPTH. They resume the cycle after a pop frees a credit.
- Boundaries:
  - cmd_len=256 from address 0x80 reads 0x80..0xFF, then 0x00..0x7F.
  - cmd_len values above 256 are illegal (assertion).

Test Plan:
- Preload RAM[i]=i+0x100. Command addr=0x10, len=4 with out_ready=1 → reads 0x10..0x13 in cycles T+1..T+4. out_data 0x110..0x113 in T+6..T+9. out_last only on 0x113; done in T+10.
- Command addr=0xFE, len=4 → addresses FE, FF, 00, 01. Data 0x1FE, 0x1FF, 0x100, 0x101.
- Command len=20 with out_ready=0 → exactly 8 reads issued, then mem_rd_read stays 0. Release out_ready → all 20 words arrive in order with no loss or duplication, and the FIFO never exceeds 8.
- Command len=0 → no mem_rd_read; done pulses one cycle after the handshake; busy stays 0.
- Pulse reset_n=0 one cycle after the 3rd read of a len=8 burst → outputs reach their reset values. Stale mem_rd_valid returns are dropped (out_valid stays 0). A new len=2 burst then returns correct data.
- Random out_ready toggling over a 256-word burst from 0x80 → the output sequence matches RAM order and out_data is stable while stalled.
